// File: rtl/alu_control_seq_if.sv
// alu_control_seq_if -- request/response bundle for alu_control_seq.
// The master side (control unit / testbench) drives the request and
// consumes the registered ALU control code plus the HI/LO results.
// DATA_W must match the DATA_W of the alu_control_seq it connects to.
interface alu_control_seq_if #(
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        alu_op;
   logic [5:0]        funct;
   logic [DATA_W-1:0] src_a;
   logic [DATA_W-1:0] src_b;
   logic              out_valid;
   logic [3:0]        alu_ctl;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;
   logic              busy;

   modport master (
      output in_valid, alu_op, funct, src_a, src_b,
      input  in_ready, out_valid, alu_ctl, hi, lo, busy
   );

   modport slave (
      input  in_valid, alu_op, funct, src_a, src_b,
      output in_ready, out_valid, alu_ctl, hi, lo, busy
   );
endinterface

// File: rtl/alu_control_seq.sv
// alu_control_seq -- MIPS-style ALU control decoder with a sequential
// unsigned multiplier (multu) and optional restoring divider (divu).
// Single-cycle codes answer one cycle after acceptance; multi-cycle ops
// run DATA_W iteration cycles, then one DONE cycle carries out_valid.
// Optional feature macro: ALU_CONTROL_SEQ_DIV_EN enables divu.
// Reset is synchronous, active-low.
module alu_control_seq #(
   parameter int DATA_W = 32
) (
   input logic               clk,
   input logic               rst_n,
   alu_control_seq_if.slave  bus
);

   localparam int CNT_W = $clog2(DATA_W);

   localparam logic [3:0] CTL_AND   = 4'b0000;
   localparam logic [3:0] CTL_OR    = 4'b0001;
   localparam logic [3:0] CTL_ADD   = 4'b0010;
   localparam logic [3:0] CTL_SUB   = 4'b0110;
   localparam logic [3:0] CTL_SLT   = 4'b0111;
   localparam logic [3:0] CTL_NOR   = 4'b1100;
   localparam logic [3:0] CTL_MULTU = 4'b1000;
   localparam logic [3:0] CTL_DIVU  = 4'b1001;
   localparam logic [3:0] CTL_BAD   = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [2*DATA_W-1:0] acc_q, step_acc;
   logic [DATA_W-1:0]   opnd_q;
   logic [DATA_W-1:0]   hi_q, lo_q;
   logic [3:0]          alu_ctl_q;
   logic                out_valid_q;
   logic                in_ready_c, busy_c, last_step;
   logic                accept;
   logic [3:0]          dec_ctl;
   logic [DATA_W:0]     mul_sum;

   // ALUOp/funct to 4-bit ALU control code.
   function automatic logic [3:0] decode(input logic [1:0] op, input logic [5:0] f);
      logic [3:0] c;
      c = CTL_BAD;
      case (op)
         2'b00: c = CTL_ADD;
         2'b01: c = CTL_SUB;
         2'b10: begin
            case (f)
               6'b100000: c = CTL_ADD;
               6'b100010: c = CTL_SUB;
               6'b100100: c = CTL_AND;
               6'b100101: c = CTL_OR;
               6'b101010: c = CTL_SLT;
               6'b100111: c = CTL_NOR;
               6'b011001: c = CTL_MULTU;
`ifdef ALU_CONTROL_SEQ_DIV_EN
               6'b011011: c = CTL_DIVU;
`endif
               default:   c = CTL_BAD;
            endcase
         end
         default: c = CTL_BAD;
      endcase
      return c;
   endfunction

   assign dec_ctl = decode(bus.alu_op, bus.funct);
   assign accept  = bus.in_valid && in_ready_c;

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic and state-derived outputs.
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_d    = state_q;
      in_ready_c = 1'b0;
      busy_c     = 1'b0;
      last_step  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_c = 1'b1;
            if (accept && dec_ctl == CTL_MULTU) state_d = MUL;
`ifdef ALU_CONTROL_SEQ_DIV_EN
            if (accept && dec_ctl == CTL_DIVU)  state_d = DIV;
`endif
         end
         MUL, DIV: begin
            busy_c = 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
               last_step = 1'b1;
               state_d   = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef ALU_CONTROL_SEQ_DIV_EN
   logic [DATA_W:0] div_shift, div_diff;
   logic            div_ge;
`endif

   // One iteration of shift-add multiply or restoring divide. Both keep the
   // high half (partial product / remainder) in acc_q[2W-1:W] and the low half
   // (multiplier bits / quotient) in acc_q[W-1:0], so completion maps the
   // halves straight onto hi/lo.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      step_acc = {mul_sum, acc_q[DATA_W-1:1]};
`ifdef ALU_CONTROL_SEQ_DIV_EN
      div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      div_ge    = div_shift >= {1'b0, opnd_q};
      // A zero divisor always subtracts: quotient fills with ones and the
      // remainder ends up as the full dividend.
      if (state_q == DIV)
         step_acc = {(div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0]),
                     acc_q[DATA_W-2:0], div_ge};
`endif
   end

   // Datapath: operand capture, iteration, result and control registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         acc_q       <= '0;
         opnd_q      <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         alu_ctl_q   <= CTL_AND;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         if (accept) begin
            if (dec_ctl == CTL_MULTU) begin
               acc_q  <= {{DATA_W{1'b0}}, bus.src_b};
               opnd_q <= bus.src_a;
               cnt_q  <= '0;
`ifdef ALU_CONTROL_SEQ_DIV_EN
            end else if (dec_ctl == CTL_DIVU) begin
               acc_q  <= {{DATA_W{1'b0}}, bus.src_a};
               opnd_q <= bus.src_b;
               cnt_q  <= '0;
`endif
            end else begin
               alu_ctl_q   <= dec_ctl;
               out_valid_q <= 1'b1;
            end
         end else if (busy_c) begin
            acc_q <= step_acc;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_step) begin
               hi_q        <= step_acc[2*DATA_W-1:DATA_W];
               lo_q        <= step_acc[DATA_W-1:0];
               alu_ctl_q   <= (state_q == MUL) ? CTL_MULTU : CTL_DIVU;
               out_valid_q <= 1'b1;
            end
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.busy      = busy_c;
   assign bus.out_valid = out_valid_q;
   assign bus.alu_ctl   = alu_ctl_q;
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;

endmodule

// File: doc/alu_control_seq.md
ALU_CONTROL_SEQ -- requirements
Module: alu_control_seq

Interface
REQ-001 Parameter: DATA_W, 32, operand and HI/LO width; legal range 8..64.
REQ-002 Port: clk  input  1  single system clock, all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: in_valid  input  1  request present on alu_op/funct/src_a/src_b.
REQ-005 Port: in_ready  output  1  block can accept a request this cycle.
REQ-006 Port: alu_op  input  2  ALUOp from control unit: 00 add (lw/sw), 01 sub (beq), 10 R-format funct, 11 reserved.
REQ-007 Port: funct  input  6  instruction funct field [5:0].
REQ-008 Port: src_a  input  DATA_W  first operand, used only by multi-cycle ops.
REQ-009 Port: src_b  input  DATA_W  second operand, used only by multi-cycle ops.
REQ-010 Port: out_valid  output  1  one-cycle pulse marking alu_ctl (and hi/lo for multi-cycle ops) valid.
REQ-011 Port: alu_ctl  output  4  registered ALU operation code.
REQ-012 Port: hi  output  DATA_W  HI register.
REQ-013 Port: lo  output  DATA_W  LO register.
REQ-014 Port: busy  output  1  multi-cycle operation in progress.

Function
REQ-015 A request SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; in_ready SHALL equal 1 exactly in state IDLE.
REQ-016 Decode: alu_op 00->0010; 01->0110; 10 with funct 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, 100111->1100, 011001 (multu)->1000; any other funct or alu_op 11->1111.
REQ-017 Single-cycle codes SHALL register alu_ctl and pulse out_valid for exactly one cycle, the cycle after acceptance; state stays IDLE; hi/lo unchanged.
REQ-018 States: IDLE, MUL, DIV, DONE; IDLE->MUL on accepted multu, IDLE->DIV on accepted divu (REQ-027), MUL/DIV->DONE after DATA_W iteration cycles, DONE->IDLE unconditionally.
REQ-019 On multu acceptance operands SHALL be latched; MUL performs one shift-add step per cycle, unsigned, full 2*DATA_W-bit product.
REQ-020 In DONE: hi = product[2*DATA_W-1:DATA_W], lo = product[DATA_W-1:0], out_valid=1, alu_ctl=1000; latency acceptance-to-out_valid = DATA_W+1 cycles.
REQ-021 busy SHALL be 1 in MUL and DIV, 0 in IDLE and DONE.
REQ-022 in_valid while in_ready=0 SHALL be ignored; no queueing, the requester holds the request.
REQ-023 alu_ctl SHALL hold its last value between out_valid pulses; hi/lo SHALL hold until the next multi-cycle completion.
REQ-024 Operand changes after acceptance SHALL NOT affect the result.

Reset
REQ-025 On rising clk with rst_n=0: state=IDLE, alu_ctl=0000, hi=0, lo=0, out_valid=0, busy=0, internal accumulators cleared; in_ready=1 from the first cycle after reset is released.
REQ-026 Reset asserted mid-MUL or mid-DIV SHALL abort the operation with no out_valid pulse and hi/lo cleared.

Configuration
REQ-027 With macro ALU_CONTROL_SEQ_DIV_EN defined: funct 011011 (divu) with alu_op 10 decodes to 1001 and runs a DATA_W-cycle restoring unsigned divide, lo=quotient, hi=remainder, latency DATA_W+1.
REQ-028 Divide-by-zero (macro defined): lo=all ones, hi=src_a, same latency as a normal divu.
REQ-029 Without ALU_CONTROL_SEQ_DIV_EN: divu decodes to 1111 as a single-cycle op, state DIV is never entered, hi/lo unchanged.

Verification
REQ-030 Reset, then alu_op=00 accepted -> next cycle out_valid=1, alu_ctl=0010; then alu_op=01 -> alu_ctl=0110.
REQ-031 alu_op=10, funct sweep 100000/100010/100100/100101/101010/100111/000000 -> alu_ctl 0010/0110/0000/0001/0111/1100/1111, one out_valid each, back-to-back acceptance every cycle.
REQ-032 DATA_W=32, multu src_a=0xFFFFFFFF, src_b=0x00000002 -> busy for 32 cycles, in_ready=0, out_valid at cycle 33 with hi=0x00000001, lo=0xFFFFFFFE, alu_ctl=1000.
REQ-033 in_valid held high with alu_op=00 during busy -> not accepted until the cycle after DONE; out_valid one cycle later with alu_ctl=0010, hi/lo retained.
REQ-034 rst_n=0 at cycle 10 of a multu -> no out_valid, hi=lo=0, in_ready=1 after release.
REQ-035 Macro defined: divu 100/7 -> lo=14, hi=2 at cycle 33; divu 5/0 -> lo=0xFFFFFFFF, hi=5; macro undefined: divu -> alu_ctl=1111 next cycle.
